// File: rtl/sdram_arbiter.sv
// sdram_arbiter: host/refresh/disk arbiter in front of a 16-bit SDRAM controller
module sdram_arbiter #(
  parameter logic [22:0] DISK_BASE = 23'h100000,
  parameter logic [22:0] VU_BASE   = 23'h000000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        access_slot,
  input  logic [17:0] vu_adrs,
  input  logic [7:0]  vu_data_i,
  output logic [7:0]  vu_data_o,
  input  logic        vu_write,
  input  logic        vu_read,
  input  logic [22:0] disk_adrs,
  input  logic [7:0]  disk_data_i,
  output logic [7:0]  disk_data_o,
  input  logic        disk_write,
  input  logic        disk_read,
  input  logic        disk_halfword,
  input  logic        disk_byte,
  output logic        disk_ram_busy,
  output logic [22:0] sdram_addr,
  input  logic [15:0] sdram_di,
  output logic [15:0] sdram_do,
  output logic        sdram_read,
  output logic        sdram_write,
  output logic        sdram_lb,
  output logic        sdram_ub,
  output logic        sdram_refresh,
  input  logic        sdram_busy
);
  localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, WAIT_ACK = 2'd2, WAIT_DONE = 2'd3;
  localparam logic [1:0] SRV_HOST = 2'd1, SRV_REF = 2'd2, SRV_DISK = 2'd3;
  logic [1:0]  st_q, st_d, cnt_q, srv_q, sel_d;
  logic        rd_q, start, done;
  logic        host_pend_q, host_wr_q, ref_pend_q, disk_pend_q, disk_wr_q, disk_hw_q;
  logic [17:0] host_adr_q;
  logic [7:0]  host_dat_q, disk_dat_q, vu_do_q, disk_do_q, rdata;
  logic [22:0] disk_adr_q, addr_q, h_addr, d_addr;
  logic [15:0] do_q;
  logic        lb_q, ub_q, rd_pulse_q, wr_pulse_q, rf_pulse_q;
  assign vu_data_o     = vu_do_q;
  assign disk_data_o   = disk_do_q;
  assign disk_ram_busy = disk_pend_q;
  assign sdram_addr    = addr_q;
  assign sdram_do      = do_q;
  assign sdram_lb      = lb_q;
  assign sdram_ub      = ub_q;
  assign sdram_read    = rd_pulse_q;
  assign sdram_write   = wr_pulse_q;
  assign sdram_refresh = rf_pulse_q;
  // Arbitration, completion detection (busy seen falling or ack timeout) and next state
  always_comb begin
    start  = st_q == IDLE && !sdram_busy && (host_pend_q || ref_pend_q || disk_pend_q);
    sel_d  = host_pend_q ? SRV_HOST : ref_pend_q ? SRV_REF : SRV_DISK;
    done   = !sdram_busy && (st_q == WAIT_DONE || (st_q == WAIT_ACK && cnt_q == 2'd3));
    st_d   = start ? ISSUE : st_q == ISSUE ? WAIT_ACK : done ? IDLE :
             (st_q == WAIT_ACK && sdram_busy) ? WAIT_DONE : st_q;
    h_addr = VU_BASE + {6'd0, host_adr_q[17:1]};
    d_addr = DISK_BASE + {1'b0, disk_adr_q[22:1]};
    rdata  = (ub_q && !lb_q) ? sdram_di[15:8] : sdram_di[7:0];
  end
  // Request latches, command issue and read-data capture; host/refresh requests leave
  // the pending set at issue so a new slot during flight is kept, disk stays busy until capture
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st_q <= IDLE; cnt_q <= 2'd0; srv_q <= 2'd0; rd_q <= 1'b0;
      host_pend_q <= 1'b0; host_wr_q <= 1'b0; host_adr_q <= '0; host_dat_q <= '0;
      ref_pend_q <= 1'b0;
      disk_pend_q <= 1'b0; disk_wr_q <= 1'b0; disk_hw_q <= 1'b0; disk_adr_q <= '0; disk_dat_q <= '0;
      addr_q <= '0; do_q <= '0; lb_q <= 1'b0; ub_q <= 1'b0;
      rd_pulse_q <= 1'b0; wr_pulse_q <= 1'b0; rf_pulse_q <= 1'b0;
      vu_do_q <= '0; disk_do_q <= '0;
    end else begin
      st_q <= st_d;
      cnt_q <= st_q == WAIT_ACK ? cnt_q + 2'd1 : 2'd0;
      rd_pulse_q <= 1'b0;
      wr_pulse_q <= 1'b0;
      rf_pulse_q <= 1'b0;
      if (start) begin
        srv_q <= sel_d;
        if (sel_d == SRV_HOST) begin
          host_pend_q <= 1'b0;
          rd_q <= !host_wr_q;
          rd_pulse_q <= !host_wr_q;
          wr_pulse_q <= host_wr_q;
          addr_q <= h_addr;
          do_q <= {2{host_dat_q}};
          lb_q <= !host_adr_q[0];
          ub_q <= host_adr_q[0];
        end else if (sel_d == SRV_REF) begin
          ref_pend_q <= 1'b0;
          rd_q <= 1'b0;
          rf_pulse_q <= 1'b1;
          addr_q <= '0;
          do_q <= '0;
          lb_q <= 1'b0;
          ub_q <= 1'b0;
        end else begin
          rd_q <= !disk_wr_q;
          rd_pulse_q <= !disk_wr_q;
          wr_pulse_q <= disk_wr_q;
          addr_q <= d_addr;
          do_q <= {2{disk_dat_q}};
          lb_q <= disk_hw_q || !disk_adr_q[0];
          ub_q <= disk_hw_q || disk_adr_q[0];
        end
      end
      if (done) begin
        addr_q <= '0;
        do_q <= '0;
        lb_q <= 1'b0;
        ub_q <= 1'b0;
        if (rd_q && srv_q == SRV_HOST) vu_do_q <= rdata;
        if (rd_q && srv_q == SRV_DISK) disk_do_q <= rdata;
        if (srv_q == SRV_DISK) disk_pend_q <= 1'b0;
      end
      if (access_slot) begin
        if (vu_read || vu_write) begin
          host_pend_q <= 1'b1;
          host_wr_q <= vu_write;
          host_adr_q <= vu_adrs;
          host_dat_q <= vu_data_i;
        end else ref_pend_q <= 1'b1;
      end
      if (!disk_pend_q && (disk_read || disk_write)) begin
        disk_pend_q <= 1'b1;
        disk_wr_q <= disk_write;
        disk_hw_q <= disk_halfword;
        disk_adr_q <= disk_adrs;
        disk_dat_q <= disk_data_i;
      end
    end
  end
endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: table-driven disk vectors plus host/refresh/timeout/reset sequences, scoreboarded commands
module tb_sdram_arbiter;
  logic clk = 0, reset_n = 0, access_slot = 0, vu_write = 0, vu_read = 0;
  logic [17:0] vu_adrs = '0;
  logic [7:0] vu_data_i = '0, vu_data_o, disk_data_i = '0, disk_data_o;
  logic [22:0] disk_adrs = '0, sdram_addr;
  logic disk_write = 0, disk_read = 0, disk_halfword = 0, disk_byte = 0, disk_ram_busy;
  logic [15:0] sdram_di = '0, sdram_do;
  logic sdram_read, sdram_write, sdram_lb, sdram_ub, sdram_refresh, sdram_busy = 0;
  logic no_ack = 0, mon_prev = 0;
  int errors = 0, checks = 0;

  typedef struct {
    logic [2:0] op; logic chk_addr; logic [22:0] addr; logic chk_do; logic [15:0] dout; logic lb, ub;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    logic [22:0] adrs; logic [7:0] d; logic rd, wr, hw, by; logic [15:0] di;
    logic [22:0] eaddr; logic elb, eub; logic [7:0] edata;
  } vec_t;
  vec_t vec[8];

  sdram_arbiter dut (
    .clk(clk), .reset_n(reset_n), .access_slot(access_slot), .vu_adrs(vu_adrs),
    .vu_data_i(vu_data_i), .vu_data_o(vu_data_o), .vu_write(vu_write), .vu_read(vu_read),
    .disk_adrs(disk_adrs), .disk_data_i(disk_data_i), .disk_data_o(disk_data_o),
    .disk_write(disk_write), .disk_read(disk_read), .disk_halfword(disk_halfword),
    .disk_byte(disk_byte), .disk_ram_busy(disk_ram_busy), .sdram_addr(sdram_addr),
    .sdram_di(sdram_di), .sdram_do(sdram_do), .sdram_read(sdram_read), .sdram_write(sdram_write),
    .sdram_lb(sdram_lb), .sdram_ub(sdram_ub), .sdram_refresh(sdram_refresh), .sdram_busy(sdram_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [2:0] op, input logic ca, input logic [22:0] a,
                      input logic cd, input logic [15:0] d, input logic lb, input logic ub);
    exp_t e;
    e.op = op; e.chk_addr = ca; e.addr = a; e.chk_do = cd; e.dout = d; e.lb = lb; e.ub = ub;
    exp_q.push_back(e);
  endtask

  task automatic wait_disk_idle(input string nm);
    int n = 0;
    while (disk_ram_busy && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk(nm, 32'(disk_ram_busy), 32'd0);
  endtask

  // Controller model: on any command pulse, raise busy one cycle later for three cycles
  initial forever begin
    @(negedge clk);
    if ((sdram_read || sdram_write || sdram_refresh) && !no_ack) begin
      @(posedge clk); #1 sdram_busy = 1;
      repeat (3) @(posedge clk);
      #1 sdram_busy = 0;
    end
  end

  // Command monitor: every pulse is popped against the scoreboard
  initial forever begin
    @(negedge clk);
    if (sdram_read || sdram_write || sdram_refresh) begin
      if (exp_q.size() == 0) chk("unexpected_cmd", 32'({sdram_refresh, sdram_write, sdram_read}), 32'd0);
      else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("cmd_op", 32'({sdram_refresh, sdram_write, sdram_read}), 32'(e.op));
        if (e.chk_addr) chk("cmd_addr", 32'(sdram_addr), 32'(e.addr));
        if (e.chk_do) chk("cmd_do", 32'(sdram_do), 32'(e.dout));
        chk("cmd_lanes", 32'({sdram_ub, sdram_lb}), 32'({e.ub, e.lb}));
        chk("cmd_pulse_len", 32'(mon_prev), 32'd0);
      end
    end
    mon_prev = sdram_read || sdram_write || sdram_refresh;
  end

  initial begin
    int n;
    vec[0] = '{23'h000003, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 16'hA55A, 23'h100001, 1'b0, 1'b1, 8'hA5};
    vec[1] = '{23'h000010, 8'h3C, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 23'h100008, 1'b1, 1'b1, 8'h00};
    vec[2] = '{23'h000004, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 16'h1234, 23'h100002, 1'b1, 1'b0, 8'h34};
    vec[3] = '{23'h000020, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 16'hBEEF, 23'h100010, 1'b1, 1'b1, 8'hEF};
    vec[4] = '{23'h7FFFFF, 8'h81, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 23'h4FFFFF, 1'b0, 1'b1, 8'h00};
    vec[5] = '{23'h000006, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 23'h100003, 1'b1, 1'b0, 8'h00};
    vec[6] = '{23'h000002, 8'h77, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0000, 23'h100001, 1'b1, 1'b0, 8'h00};
    vec[7] = '{23'h000009, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 16'hC0DE, 23'h100004, 1'b0, 1'b1, 8'hC0};

    repeat (3) @(negedge clk);
    chk("rst_addr", 32'(sdram_addr), 32'd0);
    chk("rst_cmds", 32'({sdram_read, sdram_write, sdram_refresh}), 32'd0);
    chk("rst_lanes", 32'({sdram_lb, sdram_ub}), 32'd0);
    chk("rst_disk_busy", 32'(disk_ram_busy), 32'd0);
    chk("rst_data", 32'({vu_data_o, disk_data_o}), 32'd0);
    @(posedge clk); #1 reset_n = 1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      sdram_di = vec[i].di;
      disk_adrs = vec[i].adrs; disk_data_i = vec[i].d;
      disk_read = vec[i].rd; disk_write = vec[i].wr;
      disk_halfword = vec[i].hw; disk_byte = vec[i].by;
      push(vec[i].wr ? 3'b010 : 3'b001, 1'b1, vec[i].eaddr, vec[i].wr, {vec[i].d, vec[i].d}, vec[i].elb, vec[i].eub);
      @(posedge clk); #1 disk_read = 0; disk_write = 0;
      @(negedge clk);
      chk("disk_busy_set", 32'(disk_ram_busy), 32'd1);
      wait_disk_idle("disk_done");
      if (!vec[i].wr) chk("disk_rdata", 32'(disk_data_o), 32'(vec[i].edata));
    end
    disk_halfword = 0; disk_byte = 0;

    @(posedge clk); #1 access_slot = 1;
    push(3'b100, 1'b0, 23'd0, 1'b0, 16'd0, 1'b0, 1'b0);
    @(posedge clk); #1 access_slot = 0;
    repeat (14) @(negedge clk);
    chk("refresh_no_disk_change", 32'(disk_data_o), 32'hC0);

    sdram_di = 16'h66C3;
    @(posedge clk); #1;
    disk_adrs = 23'h000003; disk_read = 1; disk_byte = 1;
    access_slot = 1; vu_read = 1; vu_adrs = 18'h00004;
    push(3'b001, 1'b1, 23'h000002, 1'b0, 16'd0, 1'b1, 1'b0);
    push(3'b001, 1'b1, 23'h100001, 1'b0, 16'd0, 1'b0, 1'b1);
    @(posedge clk); #1 disk_read = 0; access_slot = 0; vu_read = 0;
    repeat (2) @(negedge clk);
    wait_disk_idle("prio_disk_done");
    chk("prio_vu_rdata", 32'(vu_data_o), 32'hC3);
    chk("prio_disk_rdata", 32'(disk_data_o), 32'h66);

    @(posedge clk); #1 disk_adrs = 23'h000040; disk_read = 1;
    push(3'b001, 1'b1, 23'h100020, 1'b0, 16'd0, 1'b1, 1'b0);
    push(3'b010, 1'b1, 23'h000004, 1'b1, 16'h4444, 1'b0, 1'b1);
    @(posedge clk); #1 disk_read = 0;
    n = 0;
    while (!sdram_busy && n < 20) begin @(negedge clk); n++; end
    chk("ovr_busy_seen", 32'(sdram_busy), 32'd1);
    @(posedge clk); #1 access_slot = 1; vu_read = 1; vu_adrs = 18'h00008;
    @(posedge clk); #1 vu_read = 0; vu_write = 1; vu_adrs = 18'h00009; vu_data_i = 8'h44;
    @(posedge clk); #1 access_slot = 0; vu_write = 0;
    repeat (20) @(negedge clk);
    chk("ovr_disk_rdata", 32'(disk_data_o), 32'hC3);
    chk("ovr_vu_rdata_kept", 32'(vu_data_o), 32'hC3);

    no_ack = 1;
    @(posedge clk); #1 disk_adrs = 23'h000003; disk_read = 1;
    push(3'b001, 1'b1, 23'h100001, 1'b0, 16'd0, 1'b0, 1'b1);
    @(posedge clk); #1 disk_read = 0;
    n = 0;
    do begin @(negedge clk); n++; end while (!sdram_read && n < 20);
    chk("noack_issue_seen", 32'(sdram_read), 32'd1);
    n = 0;
    while (disk_ram_busy && n < 20) begin @(negedge clk); n++; end
    chk("noack_timeout_cycles", 32'(n), 32'd5);
    no_ack = 0;

    @(posedge clk); #1 disk_adrs = 23'h000010; disk_read = 1; disk_halfword = 1;
    push(3'b001, 1'b1, 23'h100008, 1'b0, 16'd0, 1'b1, 1'b1);
    @(posedge clk); #1 disk_read = 0; disk_halfword = 0;
    n = 0;
    while (!sdram_busy && n < 20) begin @(negedge clk); n++; end
    chk("rst_mid_busy_seen", 32'(sdram_busy), 32'd1);
    #2 reset_n = 0;
    #1;
    chk("rst_mid_addr", 32'(sdram_addr), 32'd0);
    chk("rst_mid_lanes", 32'({sdram_lb, sdram_ub}), 32'd0);
    chk("rst_mid_disk_busy", 32'(disk_ram_busy), 32'd0);
    chk("rst_mid_data", 32'({vu_data_o, disk_data_o}), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1;
    repeat (12) @(negedge clk);
    chk("rst_after_disk_busy", 32'(disk_ram_busy), 32'd0);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
- Two-client SDRAM arbiter sitting between the host video/CPU port ("vu"), the floppy/disk controller's SDRAM port, and a single 16-bit SDRAM_Controller.
- The host gets a guaranteed transaction at every access_slot pulse. Refresh fills unused slots. The disk client is served at lowest priority.
- Translates byte-oriented client requests into word-addressed 16-bit controller requests with byte-lane masks.

Parameters:
- DISK_BASE, 23'h100000, word-address offset added to the disk word address (keeps disk image above host RAM).
- VU_BASE, 23'h000000, word-address offset for host accesses.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- access_slot  in  1  one-cycle host slot strobe (nominally every 16 clk)
- vu_adrs  in  18  host byte address
- vu_data_i  in  8  host write data
- vu_data_o  out  8  host read data (registered)
- vu_write  in  1  host write request, sampled on access_slot
- vu_read  in  1  host read request, sampled on access_slot
- disk_adrs  in  23  disk byte address
- disk_data_i  in  8  disk write data
- disk_data_o  out  8  disk read data (registered)
- disk_write  in  1  disk write strobe
- disk_read  in  1  disk read strobe
- disk_halfword  in  1  1 = both byte lanes
- disk_byte  in  1  1 = single lane selected by disk_adrs[0]
- disk_ram_busy  out  1  disk transaction pending/active
- sdram_addr  out  23  controller word address
- sdram_di  in  16  controller read data
- sdram_do  out  16  controller write data
- sdram_read  out  1  read request pulse
- sdram_write  out  1  write request pulse
- sdram_lb  out  1  low-byte enable
- sdram_ub  out  1  high-byte enable
- sdram_refresh  out  1  refresh request pulse
- sdram_busy  in  1  controller busy

Behaviour:
- Reset (async, reset_n=0): all outputs 0, FSM in IDLE, all pending flags cleared.
- Address mapping:
  - host: sdram_addr = VU_BASE + vu_adrs[17:1]; lane = vu_adrs[0] (0 -> lb, 1 -> ub).
  - disk: sdram_addr = DISK_BASE + disk_adrs[22:1], truncated to 23 bits.
- Disk lane selection:
  - disk_halfword=1: lb=ub=1, write data {disk_data_i, disk_data_i}, read returns sdram_di[7:0].
  - else (disk_byte or neither): single lane by disk_adrs[0].
- Write data is always the byte replicated on both halves. Read data is taken from the selected lane.
- Host request latch: on access_slot, if vu_read or vu_write, latch the request (address, data, rd/wr; write wins if both). Otherwise set refresh_pending.
- Disk request latch: when disk_ram_busy=0 and disk_read or disk_write is high, latch the request (write wins if both). disk_ram_busy goes 1 the next cycle. Strobes while busy are ignored.
- FSM:
  - IDLE -> ISSUE when any request is pending and sdram_busy=0. Priority: host > refresh > disk.
  - ISSUE: exactly one cycle of sdram_read / sdram_write / sdram_refresh with addr, do and lane masks valid; then WAIT_ACK.
  - WAIT_ACK: wait for sdram_busy=1, then WAIT_DONE. If busy has not risen after 4 cycles, treat the transaction as complete.
  - WAIT_DONE: when sdram_busy=0, capture read data into vu_data_o or disk_data_o and clear the served pending flag; then IDLE.
- disk_ram_busy drops in the cycle after data capture.
- sdram_addr, sdram_do, lb and ub hold their values through WAIT_DONE. They return to 0 in IDLE. Masks are 0 during refresh.
- Simultaneous events:
  - access_slot arriving while a disk transaction is active: the host request is latched and served next, so the disk is never preempted mid-transaction.
  - A second access_slot while the host request is still pending overwrites it (the latest request wins).
- Reset mid-transaction aborts all activity and clears pending flags. The disk client must reissue.

Test Plan:
- Reset: reset_n=0 mid-transaction -> all outputs 0 immediately; disk_ram_busy=0 after release.
- Disk byte read: disk_adrs=23'h000003, disk_read pulse, controller returns sdram_di=16'hA55A -> sdram_addr=23'h100001, ub=1, lb=0; disk_data_o=8'hA5; disk_ram_busy high until the cycle after capture.
- Disk halfword write: disk_adrs=23'h000010, disk_data_i=8'h3C, halfword=1 -> sdram_write 1-cycle pulse, sdram_addr=23'h100008, sdram_do=16'h3C3C, lb=ub=1.
- Host priority: disk_read and access_slot with vu_read (vu_adrs=18'h00004) in the same cycle -> host issued first at sdram_addr=23'h000002, lb=1; disk follows after sdram_busy falls.
- Refresh: access_slot with no vu request -> one sdram_refresh pulse, lb=ub=0, no disk_data_o change.
- Missing ack: sdram_busy held 0 after a disk read -> FSM returns to IDLE after 4 cycles; disk_ram_busy clears.
